// File: rtl/prog_rom_pkg.sv
// Shared definitions for the loadable instruction memory: filler opcodes,
// controller state encoding, fetch-output source select and handshake levels.
// Imported by prog_rom and its storage sub-module.
package prog_rom_pkg;

  // jal x0, 0 : spin in place; content of swept words and of invalid fetches
  localparam logic [31:0] I_WAIT      = 32'h0000_006F;
  // wfi : presented while the memory is busy so the core holds its pc
  localparam logic [31:0] I_WAIT_STAY = 32'h1050_0073;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Which value drives inst_o, captured alongside the registered RAM read
  typedef enum logic [1:0] {
    SEL_STAY = 2'd0,
    SEL_WAIT = 2'd1,
    SEL_MEM  = 2'd2
  } isel_t;

  localparam logic HS_ON  = 1'b1;
  localparam logic HS_OFF = 1'b0;

endpackage

// File: rtl/prog_rom_mem.sv
// Single-port synchronous RAM, DEPTH x DATA_W.
// Latency: read data registered, one cycle after addr.
// No backpressure; write and read share the single address port.
module prog_rom_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port plus registered read of the same address (old data on collision)
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[addr_i] <= wdata_i;
    end
    rdata_o <= r_mem[addr_i];
  end

endmodule

// File: rtl/prog_rom.sv
// Loadable instruction memory: registered fetch port, burst loader, clear sweep.
// Latency: fetch data one cycle after pc_i; loaded word readable the cycle after its write.
// Backpressure: w_ready_o is high for the whole LOAD state; fetch is stalled (STAY) while busy.
module prog_rom
  import prog_rom_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 1024,
  parameter logic [DATA_W-1:0] WAIT_INST = DATA_W'(I_WAIT),
  parameter logic [DATA_W-1:0] STAY_INST = DATA_W'(I_WAIT_STAY)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  input  logic              load_start_i,
  input  logic [ADDR_W-1:0] load_base_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              w_valid_i,
  input  logic              w_last_i,
  output logic              w_ready_o,
  input  logic              clear_i,
  output logic              busy_o,
  output logic [ADDR_W:0]   load_cnt_o,
  output logic              err_o
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            PW       = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [AW-1:0] LAST_CLR = AW'(DEPTH - 1);

  state_t            r_state, w_state_nxt;
  isel_t             r_sel;
  logic [AW-1:0]     r_clr_ptr;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_load_cnt;
  logic              r_err;
  logic              r_inst_vld;

  logic              w_accept;
  logic              w_wr_in_range;
  logic              w_pc_oob;
  logic              w_start;
  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  // Ready is asserted for the whole LOAD state, so acceptance is just valid in LOAD
  assign w_accept      = (r_state == ST_LOAD) && (w_valid_i == HS_ON);
  assign w_wr_in_range = (r_ptr < DEPTH_P);
  assign w_pc_oob      = ({1'b0, pc_i} >= DEPTH_P);
  // clear_i has priority, so a coinciding load request must not disturb the pointers
  assign w_start       = (r_state == ST_IDLE) && load_start_i && !clear_i;

  // Controller state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded handshake/status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_ready_o   = HS_OFF;
    busy_o      = 1'b1;
    case (r_state)
      ST_CLEAR: begin
        if (!clear_i && (r_clr_ptr == LAST_CLR)) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        busy_o = 1'b0;
        if (clear_i)           w_state_nxt = ST_CLEAR;
        else if (load_start_i) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_ready_o = HS_ON;
        if (clear_i)                   w_state_nxt = ST_CLEAR;
        else if (w_accept && w_last_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  // Sweep pointer, load pointer/count, sticky error and fetch output select
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_clr_ptr  <= '0;
      r_ptr      <= '0;
      r_load_cnt <= '0;
      r_err      <= 1'b0;
      r_sel      <= SEL_STAY;
      r_inst_vld <= 1'b0;
    end else begin
      if (clear_i) begin
        r_clr_ptr <= '0;
      end else if (r_state == ST_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + AW'(1);
      end

      if (w_start) begin
        r_ptr      <= {1'b0, load_base_i};
        r_load_cnt <= '0;
      end else if (w_accept) begin
        r_ptr <= r_ptr + PW'(1);
        if (r_load_cnt != '1) r_load_cnt <= r_load_cnt + PW'(1);
      end

      if (clear_i) begin
        r_err <= 1'b0;
      end else if (((r_state == ST_IDLE) && w_pc_oob) || (w_accept && !w_wr_in_range)) begin
        r_err <= 1'b1;
      end

      if (r_state == ST_IDLE) begin
        r_sel      <= w_pc_oob ? SEL_WAIT : SEL_MEM;
        r_inst_vld <= !w_pc_oob;
      end else begin
        r_sel      <= SEL_STAY;
        r_inst_vld <= 1'b0;
      end
    end
  end

  // Single RAM port shared by sweep, loader and fetch; the state picks the owner
  always_comb begin
    w_addr  = pc_i[AW-1:0];
    w_wdata = w_data_i;
    w_we    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_addr  = r_clr_ptr;
        w_wdata = WAIT_INST;
        w_we    = 1'b1;
      end
      ST_LOAD: begin
        w_addr = r_ptr[AW-1:0];
        w_we   = w_accept && w_wr_in_range;
      end
      default: ;
    endcase
  end

  prog_rom_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_we),
    .addr_i  (w_addr),
    .wdata_i (w_wdata),
    .rdata_o (w_rdata)
  );

  // Fetch output: RAM data or one of the filler opcodes, chosen by the registered select
  always_comb begin
    case (r_sel)
      SEL_MEM:  inst_o = w_rdata;
      SEL_WAIT: inst_o = WAIT_INST;
      default:  inst_o = STAY_INST;
    endcase
  end

  assign inst_valid_o = r_inst_vld;
  assign load_cnt_o   = r_load_cnt;
  assign err_o        = r_err;

endmodule
